// File: rtl/wdpm_pkg.sv
// wdpm_pkg: shared WDPM types, widths and the NOP instruction word
package wdpm_pkg;
  localparam int PC_W_DEF = 5;
  localparam int IR_W_DEF = 16;
  localparam logic [15:0] NOP_WORD = 16'hA000;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_LD  = 4'b0101,
    OP_ST  = 4'b0110,
    OP_LDI = 4'b0111,
    OP_MOV = 4'b1000,
    OP_CMP = 4'b1001,
    OP_NOP = 4'b1010,
    OP_JMP = 4'b1011
  } opcode_t;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} seq_state_t;
endpackage

// File: rtl/seq_pc.sv
// seq_pc: program counter with sync clear, load and increment (clear > load > inc)
module seq_pc #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);
  always_ff @(posedge clk)
    pc <= clr ? '0 : load ? load_val : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: WDPM instruction sequencer (fetch/decode/exec FSM, IR, fetch timeout)
module seq_ctrl
  import wdpm_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int IR_W     = IR_W_DEF,
  parameter int FETCH_TO = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            HALT_REQ,
  output logic            PM_REQ,
  output logic [PC_W-1:0] PM_ADDR,
  input  logic            PM_VALID,
  input  logic [IR_W-1:0] PM_RDATA,
  output logic [IR_W-1:0] IR,
  input  logic            JMP,
  input  logic [PC_W-1:0] JMP_ADDR,
  output logic            EXEC_EN,
  output logic [PC_W-1:0] PC,
  output logic            BUSY,
  output logic            HALTED,
  output logic            FETCH_ERR
);
  localparam int CNT_W = $clog2(FETCH_TO + 1);
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             in_exec;
  assign in_exec = state == EXEC;
  assign PM_ADDR = PC;
  seq_pc #(.W(PC_W)) u_pc (
    .clk      (CLK),
    .clr      (!RST),
    .load     (in_exec && JMP),
    .inc      (in_exec),
    .load_val (JMP_ADDR),
    .pc       (PC)
  );
  // the timeout fires on the FETCH_TO-th consecutive edge without valid; valid on that edge wins
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      IR        <= IR_W'(NOP_WORD);
      PM_REQ    <= 1'b0;
      EXEC_EN   <= 1'b0;
      BUSY      <= 1'b0;
      HALTED    <= 1'b0;
      FETCH_ERR <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          state  <= FETCH;
          PM_REQ <= 1'b1;
          BUSY   <= 1'b1;
        end
        FETCH: if (PM_VALID) begin
          IR     <= PM_RDATA;
          cnt    <= '0;
          PM_REQ <= 1'b0;
          state  <= DECODE;
        end else if (cnt == CNT_W'(FETCH_TO - 1)) begin
          FETCH_ERR <= 1'b1;
          PM_REQ    <= 1'b0;
          BUSY      <= 1'b0;
          HALTED    <= 1'b1;
          cnt       <= '0;
          state     <= HALT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DECODE: begin
          state   <= EXEC;
          EXEC_EN <= 1'b1;
        end
        EXEC: begin
          EXEC_EN <= 1'b0;
          if (HALT_REQ) begin
            state  <= HALT;
            BUSY   <= 1'b0;
            HALTED <= 1'b1;
          end else begin
            state  <= FETCH;
            PM_REQ <= 1'b1;
          end
        end
        HALT: if (START && !HALT_REQ) begin
          state  <= FETCH;
          PM_REQ <= 1'b1;
          BUSY   <= 1'b1;
          HALTED <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: table-driven cycle-by-cycle checks of seq_ctrl plus latency sequences
module tb_seq_ctrl;
  logic        CLK = 1'b0;
  logic        RST, START, HALT_REQ, PM_VALID, JMP;
  logic [15:0] PM_RDATA;
  logic [4:0]  JMP_ADDR;
  logic        PM_REQ, EXEC_EN, BUSY, HALTED, FETCH_ERR;
  logic [4:0]  PM_ADDR, PC;
  logic [15:0] IR;
  int checks = 0;
  int errors = 0;

  seq_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
    .PM_REQ(PM_REQ), .PM_ADDR(PM_ADDR), .PM_VALID(PM_VALID), .PM_RDATA(PM_RDATA),
    .IR(IR), .JMP(JMP), .JMP_ADDR(JMP_ADDR), .EXEC_EN(EXEC_EN), .PC(PC),
    .BUSY(BUSY), .HALTED(HALTED), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, start, hreq, vld;
    logic [15:0] rd;
    logic jmp;
    logic [4:0] ja;
    logic req, ex, busy, halted, err;
    logic [4:0] pc;
    logic [15:0] ir;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, start, hreq, vld, input logic [15:0] rd,
                     input logic jmp, input logic [4:0] ja,
                     input logic req, ex, busy, halted, err,
                     input logic [4:0] pc, input logic [15:0] ir);
    vec_t v;
    v.rst = rst; v.start = start; v.hreq = hreq; v.vld = vld; v.rd = rd;
    v.jmp = jmp; v.ja = ja; v.req = req; v.ex = ex; v.busy = busy;
    v.halted = halted; v.err = err; v.pc = pc; v.ir = ir;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic run_instr(input int w, output int lat);
    int n;
    lat = -1;
    RST = 1; JMP = 0; HALT_REQ = 0; START = 1; PM_VALID = 0;
    @(posedge CLK); #1;
    START = 0; HALT_REQ = 1; n = 1;
    repeat (w) begin @(posedge CLK); #1; n++; end
    PM_VALID = 1; PM_RDATA = 16'hA000;
    @(posedge CLK); #1;
    PM_VALID = 0; n++;
    for (int i = 0; i < 10; i++) begin
      if (EXEC_EN) begin lat = n; break; end
      @(posedge CLK); #1; n++;
    end
  endtask

  initial begin
    int lat;
    add(0,0,0,0,16'h0000,0,0,  0,0,0,0,0, 0,16'hA000);
    add(0,1,0,1,16'h7777,0,0,  0,0,0,0,0, 0,16'hA000);
    add(1,0,0,0,16'h0000,0,0,  0,0,0,0,0, 0,16'hA000);
    add(1,1,0,0,16'h0000,0,0,  1,0,1,0,0, 0,16'hA000);
    add(1,0,0,1,16'h0100,0,0,  0,0,1,0,0, 0,16'h0100);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0, 0,16'h0100);
    add(1,0,0,0,16'h0000,0,0,  1,0,1,0,0, 1,16'h0100);
    add(1,0,0,1,16'h1200,0,0,  0,0,1,0,0, 1,16'h1200);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0, 1,16'h1200);
    add(1,0,0,0,16'h0000,0,0,  1,0,1,0,0, 2,16'h1200);
    add(1,0,0,1,16'hB00C,0,0,  0,0,1,0,0, 2,16'hB00C);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0, 2,16'hB00C);
    add(1,0,0,0,16'h0000,1,12, 1,0,1,0,0,12,16'hB00C);
    add(1,0,0,1,16'hB01F,0,0,  0,0,1,0,0,12,16'hB01F);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0,12,16'hB01F);
    add(1,0,0,0,16'h0000,1,31, 1,0,1,0,0,31,16'hB01F);
    add(1,0,0,1,16'h0300,1,7,  0,0,1,0,0,31,16'h0300);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0,31,16'h0300);
    add(1,0,0,0,16'h0000,0,0,  1,0,1,0,0, 0,16'h0300);
    add(1,0,0,1,16'hB004,0,0,  0,0,1,0,0, 0,16'hB004);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0, 0,16'hB004);
    add(1,0,0,0,16'h0000,1,4,  1,0,1,0,0, 4,16'hB004);
    add(1,0,0,1,16'h0400,0,0,  0,0,1,0,0, 4,16'h0400);
    add(1,0,1,0,16'h0000,0,0,  0,1,1,0,0, 4,16'h0400);
    add(1,0,1,0,16'h0000,0,0,  0,0,0,1,0, 5,16'h0400);
    add(1,1,1,0,16'h0000,0,0,  0,0,0,1,0, 5,16'h0400);
    add(1,0,0,0,16'h0000,0,0,  0,0,0,1,0, 5,16'h0400);
    add(1,1,0,0,16'h0000,0,0,  1,0,1,0,0, 5,16'h0400);
    for (int i = 0; i < 14; i++)
      add(1,(i == 0),0,0,16'h0000,0,0, 1,0,1,0,0, 5,16'h0400);
    add(1,0,0,1,16'h0500,0,0,  0,0,1,0,0, 5,16'h0500);
    add(1,0,0,0,16'h0000,0,0,  0,1,1,0,0, 5,16'h0500);
    add(1,0,0,0,16'h0000,0,0,  1,0,1,0,0, 6,16'h0500);
    for (int i = 0; i < 14; i++)
      add(1,0,0,0,16'h0000,0,0, 1,0,1,0,0, 6,16'h0500);
    add(1,0,0,0,16'h0000,0,0,  0,0,0,1,1, 6,16'h0500);
    add(1,0,0,1,16'hFFFF,0,0,  0,0,0,1,1, 6,16'h0500);
    add(1,1,0,0,16'h0000,0,0,  1,0,1,0,1, 6,16'h0500);
    add(0,0,0,1,16'h1234,0,0,  0,0,0,0,0, 0,16'hA000);
    add(1,0,0,1,16'h5555,0,0,  0,0,0,0,0, 0,16'hA000);

    foreach (tbl[r]) begin
      RST = tbl[r].rst; START = tbl[r].start; HALT_REQ = tbl[r].hreq;
      PM_VALID = tbl[r].vld; PM_RDATA = tbl[r].rd; JMP = tbl[r].jmp; JMP_ADDR = tbl[r].ja;
      @(posedge CLK); #1;
      chk("pm_req", r, 32'(PM_REQ), 32'(tbl[r].req));
      chk("exec_en", r, 32'(EXEC_EN), 32'(tbl[r].ex));
      chk("busy", r, 32'(BUSY), 32'(tbl[r].busy));
      chk("halted", r, 32'(HALTED), 32'(tbl[r].halted));
      chk("fetch_err", r, 32'(FETCH_ERR), 32'(tbl[r].err));
      chk("pc", r, 32'(PC), 32'(tbl[r].pc));
      chk("pm_addr", r, 32'(PM_ADDR), 32'(tbl[r].pc));
      chk("ir", r, 32'(IR), 32'(tbl[r].ir));
    end

    run_instr(0, lat);
    chk("latency_nowait", 0, 32'(lat), 32'd3);
    @(posedge CLK); #1;
    chk("halt_after_nowait", 0, 32'(HALTED), 32'd1);
    chk("pc_after_nowait", 0, 32'(PC), 32'd1);
    run_instr(2, lat);
    chk("latency_wait2", 1, 32'(lat), 32'd5);
    @(posedge CLK); #1;
    chk("halt_after_wait2", 1, 32'(HALTED), 32'd1);
    chk("pc_after_wait2", 1, 32'(PC), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
